pushbutton_conditioner: RTL and testbench

//  Front end for the lab1 push buttons: synchronises, polarity-corrects and debounces NUM_BUTTONS raw pad inputs.

---
 rtl/pushbutton_conditioner_pkg.sv | 15 +
 rtl/pushbutton_conditioner_if.sv | 36 +++
 rtl/pushbutton_conditioner_debounce_channel.sv | 132 +++++++++++++
 rtl/pushbutton_conditioner.sv | 61 ++++++
 tb/tb_pushbutton_conditioner.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/pushbutton_conditioner_pkg.sv
// rtl/pushbutton_conditioner_pkg.sv - shared types and defaults for the push-button conditioner
package pushbutton_conditioner_pkg;

   // Per-channel debounce state: settled low, qualifying high, settled high, qualifying low
   typedef enum logic [1:0] {
      S_LOW,
      S_WAIT_HIGH,
      S_HIGH,
      S_WAIT_LOW
   } debounce_state_t;

   // 10 ms of stable samples at 50 MHz
   localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/pushbutton_conditioner_if.sv
// rtl/pushbutton_conditioner_if.sv - raw pad inputs and conditioned button outputs
interface pushbutton_conditioner_if #(
   parameter int NUM_BUTTONS = 3
);

   logic [NUM_BUTTONS-1:0] push_button;
   logic [NUM_BUTTONS-1:0] level;
   logic [NUM_BUTTONS-1:0] rise;
   logic [NUM_BUTTONS-1:0] fall;
   logic                   any_level;
   logic                   any_rise;
   logic                   any_fall;

   // Drives the pads and observes the conditioned outputs
   modport master (
      output push_button,
      input  level,
      input  rise,
      input  fall,
      input  any_level,
      input  any_rise,
      input  any_fall
   );

   // The conditioner itself
   modport slave (
      input  push_button,
      output level,
      output rise,
      output fall,
      output any_level,
      output any_rise,
      output any_fall
   );

endinterface

// File: rtl/pushbutton_conditioner_debounce_channel.sv
// rtl/pushbutton_conditioner_debounce_channel.sv - sync, polarity fix and debounce for one button
module pushbutton_conditioner_debounce_channel
   import pushbutton_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter bit ACTIVE_LOW      = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic pad,
   output logic level,
   output logic rise,
   output logic fall,
   output logic level_next
);

   localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_ONE = CW'(1);
   localparam logic [CW-1:0]  CNT_ACC = CW'(DEBOUNCE_CYCLES - 1);
   // With a single required sample there is nothing to count, so accept straight away
   localparam bit             DIRECT  = (DEBOUNCE_CYCLES == 1);

   logic [1:0]      sync_q;
   logic            s;
   debounce_state_t state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            level_q, level_d;
   logic            rise_q, rise_d;
   logic            fall_q, fall_d;

   // Two-flop synchroniser, reset to the idle pad value so reset never looks like a press
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= {2{ACTIVE_LOW}};
      end else begin
         sync_q <= {sync_q[0], pad};
      end
   end

   assign s = sync_q[1] ^ ACTIVE_LOW;

   // Debounce state, counter and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_LOW;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   // Next state: a new level is accepted only after DEBOUNCE_CYCLES consecutive agreeing samples
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         S_LOW: begin
            if (s) begin
               if (DIRECT) begin
                  state_d = S_HIGH;
                  cnt_d   = '0;
                  level_d = 1'b1;
                  rise_d  = 1'b1;
               end else begin
                  state_d = S_WAIT_HIGH;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         S_WAIT_HIGH: begin
            if (!s) begin
               state_d = S_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_ACC) begin
               state_d = S_HIGH;
               cnt_d   = '0;
               level_d = 1'b1;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_HIGH: begin
            if (!s) begin
               if (DIRECT) begin
                  state_d = S_LOW;
                  cnt_d   = '0;
                  level_d = 1'b0;
                  fall_d  = 1'b1;
               end else begin
                  state_d = S_WAIT_LOW;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         S_WAIT_LOW: begin
            if (s) begin
               state_d = S_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_ACC) begin
               state_d = S_LOW;
               cnt_d   = '0;
               level_d = 1'b0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = S_LOW;
            cnt_d   = '0;
            level_d = 1'b0;
         end
      endcase
   end

   assign level      = level_q;
   assign rise       = rise_q;
   assign fall       = fall_q;
   assign level_next = level_d;

endmodule

// File: rtl/pushbutton_conditioner.sv
// rtl/pushbutton_conditioner.sv - debounced level/edge outputs and any-button aggregates
module pushbutton_conditioner
   import pushbutton_conditioner_pkg::*;
#(
   parameter int NUM_BUTTONS     = 3,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter bit ACTIVE_LOW      = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst,
   pushbutton_conditioner_if.slave bus
);

   logic [NUM_BUTTONS-1:0] level;
   logic [NUM_BUTTONS-1:0] rise;
   logic [NUM_BUTTONS-1:0] fall;
   logic [NUM_BUTTONS-1:0] level_next;
   logic                   any_next;
   logic                   any_level_q;
   logic                   any_rise_q;
   logic                   any_fall_q;

   for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
      pushbutton_conditioner_debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .ACTIVE_LOW      (ACTIVE_LOW)
      ) u_chan (
         .clk        (clk),
         .rst        (rst),
         .pad        (bus.push_button[i]),
         .level      (level[i]),
         .rise       (rise[i]),
         .fall       (fall[i]),
         .level_next (level_next[i])
      );
   end

   // Built from next-state levels so the aggregate lands in the same cycle as the per-button level
   assign any_next = |level_next;

   // Any-button level and its edges; a hand-over between buttons keeps any_next high and pulses nothing
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         any_level_q <= 1'b0;
         any_rise_q  <= 1'b0;
         any_fall_q  <= 1'b0;
      end else begin
         any_level_q <= any_next;
         any_rise_q  <= !any_level_q && any_next;
         any_fall_q  <= any_level_q && !any_next;
      end
   end

   assign bus.level     = level;
   assign bus.rise      = rise;
   assign bus.fall      = fall;
   assign bus.any_level = any_level_q;
   assign bus.any_rise  = any_rise_q;
   assign bus.any_fall  = any_fall_q;

endmodule

// File: tb/tb_pushbutton_conditioner.sv
// tb/tb_pushbutton_conditioner.sv - scoreboard bench for the push-button conditioner
module tb_pushbutton_conditioner;

   typedef struct {
      int         at;
      logic [2:0] rise;
      logic [2:0] fall;
      logic       any_rise;
      logic       any_fall;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   ev_t        sb[$];
   logic [2:0] exp_level;
   logic [11:0] e;
   logic [11:0] o;

   pushbutton_conditioner_if #(.NUM_BUTTONS(3)) b0 ();
   pushbutton_conditioner_if #(.NUM_BUTTONS(3)) b1 ();

   pushbutton_conditioner #(
      .NUM_BUTTONS     (3),
      .DEBOUNCE_CYCLES (4),
      .ACTIVE_LOW      (1'b0)
   ) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (b0)
   );

   pushbutton_conditioner #(
      .NUM_BUTTONS     (3),
      .DEBOUNCE_CYCLES (4),
      .ACTIVE_LOW      (1'b1)
   ) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (b1)
   );

   always #5 clk = ~clk;

   // Expected outputs after edge k: pulses from the scoreboard, level accumulated from them
   task automatic model_step(input int k, output logic [11:0] ex);
      ev_t ev;
      ev = '{0, 3'b000, 3'b000, 1'b0, 1'b0};
      if (sb.size() != 0 && sb[0].at == k) ev = sb.pop_front();
      exp_level = (exp_level | ev.rise) & ~ev.fall;
      ex = {exp_level, ev.rise, ev.fall, |exp_level, ev.any_rise, ev.any_fall};
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      exp_level = 3'b000;
      sb.delete();
   endtask

   task automatic test_reset();
      b0.push_button = 3'b000;
      b1.push_button = 3'b111;
      #1 rst = 1'b1;
      exp_level = 3'b000;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         o = {b0.level, b0.rise, b0.fall, b0.any_level, b0.any_rise, b0.any_fall};
         checks++;
         if (o !== 12'h000) begin errors++; $display("FAIL reset_b0 cyc %0d got %b exp %b", k, o, 12'h000); end
         o = {b1.level, b1.rise, b1.fall, b1.any_level, b1.any_rise, b1.any_fall};
         checks++;
         if (o !== 12'h000) begin errors++; $display("FAIL reset_b1 cyc %0d got %b exp %b", k, o, 12'h000); end
      end
      @(posedge clk);
      #1 rst = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         o = {b0.level, b0.rise, b0.fall, b0.any_level, b0.any_rise, b0.any_fall};
         checks++;
         if (o !== 12'h000) begin errors++; $display("FAIL post_reset_b0 cyc %0d got %b exp %b", k, o, 12'h000); end
         o = {b1.level, b1.rise, b1.fall, b1.any_level, b1.any_rise, b1.any_fall};
         checks++;
         if (o !== 12'h000) begin errors++; $display("FAIL post_reset_b1 cyc %0d got %b exp %b", k, o, 12'h000); end
      end
   endtask

   task automatic test_clean_press();
      do_reset();
      sb.push_back('{16, 3'b001, 3'b000, 1'b1, 1'b0});
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk);
         #1;
         if (k == 10) b0.push_button[0] = 1'b1;
         @(negedge clk);
         model_step(k, e);
         o = {b0.level, b0.rise, b0.fall, b0.any_level, b0.any_rise, b0.any_fall};
         checks++;
         if (o !== e) begin errors++; $display("FAIL clean_press cyc %0d got %b exp %b", k, o, e); end
      end
      b0.push_button = 3'b000;
   endtask

   task automatic test_bounce();
      logic [4:0] pat;
      do_reset();
      pat = 5'b01101;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk);
         #1;
         if (k >= 10 && k <= 14) b0.push_button[1] = pat[k-10];
         @(negedge clk);
         model_step(k, e);
         o = {b0.level, b0.rise, b0.fall, b0.any_level, b0.any_rise, b0.any_fall};
         checks++;
         if (o !== e) begin errors++; $display("FAIL bounce cyc %0d got %b exp %b", k, o, e); end
      end
   endtask

   task automatic test_overlap();
      do_reset();
      sb.push_back('{16, 3'b001, 3'b000, 1'b1, 1'b0});
      sb.push_back('{26, 3'b100, 3'b000, 1'b0, 1'b0});
      sb.push_back('{36, 3'b000, 3'b001, 1'b0, 1'b0});
      sb.push_back('{46, 3'b000, 3'b100, 1'b0, 1'b1});
      for (int k = 1; k <= 55; k++) begin
         @(posedge clk);
         #1;
         if (k == 10) b0.push_button[0] = 1'b1;
         if (k == 20) b0.push_button[2] = 1'b1;
         if (k == 30) b0.push_button[0] = 1'b0;
         if (k == 40) b0.push_button[2] = 1'b0;
         @(negedge clk);
         model_step(k, e);
         o = {b0.level, b0.rise, b0.fall, b0.any_level, b0.any_rise, b0.any_fall};
         checks++;
         if (o !== e) begin errors++; $display("FAIL overlap cyc %0d got %b exp %b", k, o, e); end
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      sb.push_back('{16, 3'b111, 3'b000, 1'b1, 1'b0});
      sb.push_back('{36, 3'b000, 3'b111, 1'b0, 1'b1});
      for (int k = 1; k <= 45; k++) begin
         @(posedge clk);
         #1;
         if (k == 10) b0.push_button = 3'b111;
         if (k == 30) b0.push_button = 3'b000;
         @(negedge clk);
         model_step(k, e);
         o = {b0.level, b0.rise, b0.fall, b0.any_level, b0.any_rise, b0.any_fall};
         checks++;
         if (o !== e) begin errors++; $display("FAIL simultaneous cyc %0d got %b exp %b", k, o, e); end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      sb.push_back('{16, 3'b001, 3'b000, 1'b1, 1'b0});
      sb.push_back('{26, 3'b010, 3'b001, 1'b0, 1'b0});
      sb.push_back('{36, 3'b000, 3'b010, 1'b0, 1'b1});
      for (int k = 1; k <= 45; k++) begin
         @(posedge clk);
         #1;
         if (k == 10) b0.push_button = 3'b001;
         if (k == 20) b0.push_button = 3'b010;
         if (k == 30) b0.push_button = 3'b000;
         @(negedge clk);
         model_step(k, e);
         o = {b0.level, b0.rise, b0.fall, b0.any_level, b0.any_rise, b0.any_fall};
         checks++;
         if (o !== e) begin errors++; $display("FAIL back_to_back cyc %0d got %b exp %b", k, o, e); end
      end
      b0.push_button = 3'b000;
   endtask

   task automatic test_reset_mid();
      do_reset();
      sb.push_back('{16, 3'b001, 3'b000, 1'b1, 1'b0});
      sb.push_back('{27, 3'b001, 3'b000, 1'b1, 1'b0});
      for (int k = 1; k <= 35; k++) begin
         @(posedge clk);
         #1;
         if (k == 10) b0.push_button[0] = 1'b1;
         if (k == 18) begin
            rst = 1'b1;
            exp_level = 3'b000;
         end
         if (k == 21) rst = 1'b0;
         @(negedge clk);
         model_step(k, e);
         o = {b0.level, b0.rise, b0.fall, b0.any_level, b0.any_rise, b0.any_fall};
         checks++;
         if (o !== e) begin errors++; $display("FAIL reset_mid cyc %0d got %b exp %b", k, o, e); end
      end
      b0.push_button = 3'b000;
   endtask

   task automatic test_active_low();
      b1.push_button = 3'b111;
      do_reset();
      sb.push_back('{16, 3'b001, 3'b000, 1'b1, 1'b0});
      sb.push_back('{36, 3'b000, 3'b001, 1'b0, 1'b1});
      for (int k = 1; k <= 45; k++) begin
         @(posedge clk);
         #1;
         if (k == 10) b1.push_button[0] = 1'b0;
         if (k == 30) b1.push_button[0] = 1'b1;
         @(negedge clk);
         model_step(k, e);
         o = {b1.level, b1.rise, b1.fall, b1.any_level, b1.any_rise, b1.any_fall};
         checks++;
         if (o !== e) begin errors++; $display("FAIL active_low cyc %0d got %b exp %b", k, o, e); end
      end
   endtask

   initial begin
      b0.push_button = 3'b000;
      b1.push_button = 3'b111;
      exp_level = 3'b000;
      test_reset();
      test_clean_press();
      test_bounce();
      test_overlap();
      test_simultaneous();
      test_back_to_back();
      test_reset_mid();
      test_active_low();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
